fetch_prefetch_queue: RTL and testbench
=======================================

// Module: fetch_prefetch_queue
// PURPOSE
//   Instruction-fetch front end feeding the IF/ID pipeline register. Owns the fetch PC,
//   drives the instruction memory address, and buffers {pc, instruction} pairs in a
//   small FIFO. The decode side drains the FIFO with a valid/ready handshake. A taken
//   branch from EX/MEM redirects fetch and flushes every buffered entry.
// PARAMETERS
//   DEPTH       4    queue entries; power of two, >=2
//   PC_WIDTH    64   fetch PC / address width
//   INSTR_WIDTH 32   instruction word width
//   RESET_PC    0    fetch PC value after reset
// PORTS
//   clk           in   1                  clock, all state on rising edge
//   reset         in   1                  asynchronous, active-high
//   imem_addr     out  PC_WIDTH           instruction memory address (= fetch PC)
//   imem_rdata    in   INSTR_WIDTH        instruction word, combinational from imem_addr
//   redirect_valid in  1                  taken branch: flush queue, reload fetch PC
//   redirect_pc   in   PC_WIDTH           branch target
//   out_valid     out  1                  queue head valid
//   out_ready     in   1                  IF/ID accepts head this cycle
//   out_pc        out  PC_WIDTH           PC of head entry
//   out_instr     out  INSTR_WIDTH        instruction of head entry
//   count         out  $clog2(DEPTH)+1    occupied entries, 0..DEPTH
// BEHAVIOUR
//   - Reset (async assert, sync-to-clk deassert not required): fetch_pc=RESET_PC, rd/wr
//     pointers=0, count=0, out_valid=0, out_pc=0, out_instr=0, imem_addr=RESET_PC.
//   - imem_addr = fetch_pc (register output, no combinational path from inputs).
//   - pop = out_valid & out_ready. push = ~redirect_valid & (count<DEPTH | pop).
//   - On push: entry[wr]={fetch_pc, imem_rdata}; wr=wr+1 mod DEPTH; fetch_pc+=4.
//   - On pop: rd=rd+1 mod DEPTH. Push and pop in the same cycle leave count unchanged,
//     including when full (FULL with pop still pushes).
//   - out_valid = (count!=0); out_pc/out_instr = entry[rd]; when empty they hold 0.
//   - Latency: instruction fetched in cycle N appears at head in cycle N+1 if queue was
//     empty; one instruction pushed per cycle at most.
//   - Occupancy states: EMPTY (count=0), PARTIAL, FULL (count=DEPTH). Full without pop:
//     no push, fetch_pc holds, imem_addr stable.
//   - Redirect (highest priority after reset): next cycle count=0, rd=wr=0,
//     fetch_pc={redirect_pc[PC_WIDTH-1:2],2'b00}; no push that cycle. A pop in the
//     redirect cycle is a completed transfer (consumer owns it); all other entries dropped.
//   - Back-to-back redirects: last one wins; queue stays empty until redirect drops.
//   - fetch_pc arithmetic wraps modulo 2^PC_WIDTH (all-ones-minus-3 + 4 -> 0).
//   - Reset mid-operation: all entries discarded immediately, outputs to reset values
//     combinationally with reset assertion.
// TESTING
//   1. Reset, out_ready=1, imem holds words at 0,4,8 -> out_valid from cycle 1,
//      out_pc 0x0,0x4,0x8 on consecutive cycles, count stays 1.
//   2. out_ready=0 for 10 cycles after reset -> count reaches 4 and holds,
//      imem_addr stays 0x10, out_pc stays 0x0.
//   3. Full queue, out_ready=1 for one cycle -> count stays 4, next out_pc=0x4,
//      imem_addr advances 0x10->0x14.
//   4. count=3, redirect_valid=1 redirect_pc=0x43 -> next cycle count=0, out_valid=0,
//      imem_addr=0x40; following cycle out_valid=1 out_pc=0x40.
//   5. Redirect to 0xFFFF_FFFF_FFFF_FFFC, out_ready=1 -> out_pc sequence
//      0xFFFF_FFFF_FFFF_FFFC then 0x0.
//   6. Assert reset mid-stream with count=2 -> out_valid=0, count=0, imem_addr=RESET_PC
//      without waiting for a clock edge; fetch resumes from RESET_PC after release.

Source files
------------

// File: rtl/fetch_prefetch_queue_if.sv
// Bundles the fetch front end's bus signals: the instruction memory port,
// the branch redirect from EX/MEM and the decode-side valid/ready drain.
//   master : the fetch queue (drives imem_addr, out_*, count)
//   slave  : the environment (instruction memory, branch unit, IF/ID consumer)
// Signals:
//   imem_addr      fetch PC presented to instruction memory
//   imem_rdata     instruction word, combinational from imem_addr
//   redirect_valid taken branch, flush and reload fetch PC
//   redirect_pc    branch target
//   out_valid      queue head valid
//   out_ready      consumer accepts the head this cycle
//   out_pc         PC of the head entry
//   out_instr      instruction of the head entry
//   count          occupied entries, 0..DEPTH
interface fetch_prefetch_queue_if #(
  parameter int DEPTH       = 4,
  parameter int PC_WIDTH    = 64,
  parameter int INSTR_WIDTH = 32
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [PC_WIDTH-1:0]    imem_addr;
  logic [INSTR_WIDTH-1:0] imem_rdata;
  logic                   redirect_valid;
  logic [PC_WIDTH-1:0]    redirect_pc;
  logic                   out_valid;
  logic                   out_ready;
  logic [PC_WIDTH-1:0]    out_pc;
  logic [INSTR_WIDTH-1:0] out_instr;
  logic [CNT_W-1:0]       count;

  modport master (
    output imem_addr,
    input  imem_rdata,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_pc,
    output out_instr,
    output count
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_pc,
    input  out_instr,
    input  count
  );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end. Owns the fetch PC, drives the instruction
// memory address and buffers {pc, instruction} pairs in a DEPTH-entry FIFO
// drained by the decode stage with valid/ready. A taken branch redirects
// fetch and flushes every buffered entry.
// Ports:
//   clk    rising-edge clock for all state
//   reset  asynchronous, active-high; clears fetch PC, pointers and count
//   bus    fetch_prefetch_queue_if.master (memory port, redirect, drain)
module fetch_prefetch_queue #(
  parameter int                   DEPTH       = 4,
  parameter int                   PC_WIDTH    = 64,
  parameter int                   INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  fetch_prefetch_queue_if.master     bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PC_WIDTH-1:0]    fetch_pc;
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W-1:0]       wr_ptr;
  logic [CNT_W-1:0]       occ;

  // Payload storage: no reset needed, occupancy gates every read.
  logic [PC_WIDTH-1:0]    pc_mem    [DEPTH];
  logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];

  logic empty;
  logic full;
  logic pop;
  logic push;

  assign empty = (occ == '0);
  assign full  = (occ == CNT_W'(DEPTH));
  assign pop   = ~empty & bus.out_ready;
  // A pop frees a slot in the same cycle, so a full queue still accepts
  // a new fetch when the head is being drained.
  assign push  = ~bus.redirect_valid & (~full | pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      occ      <= '0;
    end else if (bus.redirect_valid) begin
      // Flush: any head popped this cycle already belongs to the consumer.
      fetch_pc <= bus.redirect_pc & ~PC_WIDTH'(3);
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      occ      <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        fetch_pc <= fetch_pc + PC_WIDTH'(4);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= fetch_pc;
      instr_mem[wr_ptr] <= bus.imem_rdata;
    end
  end

  assign bus.imem_addr = fetch_pc;
  assign bus.count     = occ;
  assign bus.out_valid = ~empty;
  assign bus.out_pc    = empty ? '0 : pc_mem[rd_ptr];
  assign bus.out_instr = empty ? '0 : instr_mem[rd_ptr];

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue. The instruction memory model
// returns addr[31:0] + 0x1000_0000 so every expected instruction word can
// be written down by hand from its PC.
module tb_fetch_prefetch_queue;
  localparam int DEPTH       = 4;
  localparam int PC_WIDTH    = 64;
  localparam int INSTR_WIDTH = 32;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_failed;

  fetch_prefetch_queue_if #(
    .DEPTH(DEPTH), .PC_WIDTH(PC_WIDTH), .INSTR_WIDTH(INSTR_WIDTH)
  ) ifc ();

  fetch_prefetch_queue #(
    .DEPTH(DEPTH), .PC_WIDTH(PC_WIDTH), .INSTR_WIDTH(INSTR_WIDTH),
    .RESET_PC(64'h0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.master)
  );

  assign ifc.imem_rdata = ifc.imem_addr[31:0] + 32'h1000_0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_failed++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Assert reset away from any edge, check the asynchronous clear, then
  // release on the falling edge.
  task automatic do_reset(input string tag);
    ifc.redirect_valid = 1'b0;
    ifc.redirect_pc    = '0;
    ifc.out_ready      = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_val({tag, "_valid"}, 64'(ifc.out_valid), 64'h0);
    check_val({tag, "_count"}, 64'(ifc.count), 64'h0);
    check_val({tag, "_addr"},  ifc.imem_addr, 64'h0);
    check_val({tag, "_pc"},    ifc.out_pc, 64'h0);
    check_val({tag, "_instr"}, 64'(ifc.out_instr), 64'h0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    n_tests  = 0;
    n_failed = 0;
    reset    = 1'b0;

    // 1: streaming with out_ready held high
    do_reset("rst1");
    ifc.out_ready = 1'b1;
    tick();
    check_val("t1_valid0", 64'(ifc.out_valid), 64'h1);
    check_val("t1_pc0",    ifc.out_pc, 64'h0);
    check_val("t1_instr0", 64'(ifc.out_instr), 64'h1000_0000);
    check_val("t1_count0", 64'(ifc.count), 64'h1);
    tick();
    check_val("t1_pc1",    ifc.out_pc, 64'h4);
    check_val("t1_count1", 64'(ifc.count), 64'h1);
    tick();
    check_val("t1_pc2",    ifc.out_pc, 64'h8);
    check_val("t1_instr2", 64'(ifc.out_instr), 64'h1000_0008);
    check_val("t1_count2", 64'(ifc.count), 64'h1);

    // 2: stalled consumer fills the queue
    do_reset("rst2");
    for (int i = 0; i < 10; i++) tick();
    check_val("t2_count", 64'(ifc.count), 64'h4);
    check_val("t2_addr",  ifc.imem_addr, 64'h10);
    check_val("t2_pc",    ifc.out_pc, 64'h0);
    check_val("t2_instr", 64'(ifc.out_instr), 64'h1000_0000);

    // 3: full queue, single pop still pushes
    ifc.out_ready = 1'b1;
    tick();
    ifc.out_ready = 1'b0;
    check_val("t3_count", 64'(ifc.count), 64'h4);
    check_val("t3_pc",    ifc.out_pc, 64'h4);
    check_val("t3_addr",  ifc.imem_addr, 64'h14);
    tick();
    check_val("t3_hold",  ifc.imem_addr, 64'h14);

    // 4: redirect with count=3 flushes and realigns target
    do_reset("rst4");
    for (int i = 0; i < 3; i++) tick();
    check_val("t4_count3", 64'(ifc.count), 64'h3);
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc    = 64'h43;
    tick();
    ifc.redirect_valid = 1'b0;
    ifc.out_ready      = 1'b1;
    check_val("t4_count", 64'(ifc.count), 64'h0);
    check_val("t4_valid", 64'(ifc.out_valid), 64'h0);
    check_val("t4_addr",  ifc.imem_addr, 64'h40);
    tick();
    check_val("t4_valid1", 64'(ifc.out_valid), 64'h1);
    check_val("t4_pc",     ifc.out_pc, 64'h40);
    check_val("t4_instr",  64'(ifc.out_instr), 64'h1000_0040);

    // 5: fetch PC wraps past all-ones
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    ifc.redirect_valid = 1'b0;
    check_val("t5_count", 64'(ifc.count), 64'h0);
    check_val("t5_addr",  ifc.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    check_val("t5_pc0",    ifc.out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check_val("t5_instr0", 64'(ifc.out_instr), 64'h0FFF_FFFC);
    check_val("t5_addr1",  ifc.imem_addr, 64'h0);
    tick();
    check_val("t5_pc1",    ifc.out_pc, 64'h0);
    check_val("t5_instr1", 64'(ifc.out_instr), 64'h1000_0000);

    // back-to-back redirects: last one wins, queue stays empty meanwhile
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc    = 64'h100;
    tick();
    ifc.redirect_pc    = 64'h205;
    tick();
    check_val("bb_count", 64'(ifc.count), 64'h0);
    check_val("bb_addr",  ifc.imem_addr, 64'h204);
    ifc.redirect_valid = 1'b0;
    tick();
    check_val("bb_pc",    ifc.out_pc, 64'h204);

    // 6: asynchronous reset mid-stream with count=2
    ifc.out_ready = 1'b0;
    do_reset("rst6a");
    tick();
    tick();
    check_val("t6_count2", 64'(ifc.count), 64'h2);
    #2;
    reset = 1'b1;
    #1;
    check_val("t6_valid", 64'(ifc.out_valid), 64'h0);
    check_val("t6_count", 64'(ifc.count), 64'h0);
    check_val("t6_addr",  ifc.imem_addr, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    ifc.out_ready = 1'b1;
    tick();
    check_val("t6_resume_pc",    ifc.out_pc, 64'h0);
    check_val("t6_resume_count", 64'(ifc.count), 64'h1);
    check_val("t6_resume_addr",  ifc.imem_addr, 64'h4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
